// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle controller and the RV32I datapath
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               Btaken;
    logic               mem_ready;

    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               MemReq;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrc_A;
    logic [1:0]         ALUSrc_B;
    logic [2:0]         ImmSrc;
    logic [4:0]         ALUControl;
    logic               Branch;
    logic               illegal;
    logic [STATE_W-1:0] state_dbg;

    // master = controller, slave = datapath/memory side
    modport master (
        input  opcode, funct3, funct7b5, Btaken, mem_ready,
        output PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
               ResultSrc, ALUSrc_A, ALUSrc_B, ImmSrc, ALUControl,
               Branch, illegal, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7b5, Btaken, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
               ResultSrc, ALUSrc_A, ALUSrc_B, ImmSrc, ALUControl,
               Branch, illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FSM sequencing a shared multicycle RV32I datapath with memory wait states and trap
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    state_t state, next_state;
    logic   illegal_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    // Outputs are gated by n_rst so an in-flight memory access drops the moment reset asserts.
    always_comb begin
        next_state     = state;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemReq     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'd0;
        bus.ALUSrc_A   = 2'd0;
        bus.ALUSrc_B   = 2'd0;
        bus.ImmSrc     = 3'd0;
        bus.ALUControl = ALU_ADD;
        bus.Branch     = 1'b0;
        if (n_rst) begin
            case (state)
                S_FETCH: begin
                    bus.MemReq    = 1'b1;
                    bus.ALUSrc_B  = 2'd2;
                    bus.ResultSrc = 2'd2;
                    bus.IRWrite   = bus.mem_ready;
                    bus.PCWrite   = bus.mem_ready;
                    if (bus.mem_ready)
                        next_state = S_DECODE;
                end
                S_DECODE: begin
                    bus.ALUSrc_A = 2'd1;
                    bus.ALUSrc_B = 2'd1;
                    bus.ImmSrc   = 3'd2;
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_RTYPE:          next_state = S_EXECR;
                        OP_ITYPE:          next_state = S_EXECI;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALR;
                        OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                        default:           next_state = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrc_A = 2'd2;
                    bus.ALUSrc_B = 2'd1;
                    if (bus.opcode == OP_STORE) begin
                        bus.ImmSrc = 3'd1;
                        next_state = S_MEMWRITE;
                    end else begin
                        next_state = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    bus.MemReq = 1'b1;
                    bus.AdrSrc = 1'b1;
                    if (bus.mem_ready)
                        next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    bus.ResultSrc = 2'd1;
                    bus.RegWrite  = 1'b1;
                    next_state    = S_FETCH;
                end
                S_MEMWRITE: begin
                    bus.MemReq   = 1'b1;
                    bus.MemWrite = 1'b1;
                    bus.AdrSrc   = 1'b1;
                    if (bus.mem_ready)
                        next_state = S_FETCH;
                end
                S_EXECR: begin
                    bus.ALUSrc_A   = 2'd2;
                    bus.ALUControl = {1'b0, bus.funct3,
                                      ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)) ? bus.funct7b5 : 1'b0};
                    next_state     = S_ALUWB;
                end
                S_EXECI: begin
                    // Only shifts carry funct7b5; addi with IR[30] set is still an add.
                    bus.ALUSrc_A   = 2'd2;
                    bus.ALUSrc_B   = 2'd1;
                    bus.ALUControl = {1'b0, bus.funct3, (bus.funct3 == 3'b101) ? bus.funct7b5 : 1'b0};
                    next_state     = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.RegWrite = 1'b1;
                    next_state   = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALUSrc_A   = 2'd2;
                    bus.ALUControl = ALU_SUB;
                    bus.Branch     = 1'b1;
                    bus.PCWrite    = bus.Btaken;
                    next_state     = S_FETCH;
                end
                S_JAL: begin
                    bus.ALUSrc_A = 2'd1;
                    bus.ALUSrc_B = 2'd2;
                    bus.PCWrite  = 1'b1;
                    next_state   = S_ALUWB;
                end
                S_JALR: begin
                    bus.ALUSrc_A  = 2'd2;
                    bus.ALUSrc_B  = 2'd1;
                    bus.ResultSrc = 2'd2;
                    bus.PCWrite   = 1'b1;
                    next_state    = S_ALUWB;
                end
                S_UPPER: begin
                    bus.ImmSrc   = 3'd3;
                    bus.ALUSrc_B = 2'd1;
                    bus.ALUSrc_A = (bus.opcode == OP_LUI) ? 2'd3 : 2'd1;
                    next_state   = S_ALUWB;
                end
                S_TRAP: begin
                    next_state = S_TRAP;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    assign bus.illegal   = illegal_q;
    assign bus.state_dbg = STATE_W'(state);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with randomized instruction stream
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       mr;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [4:0] alu;
        logic       br;
        logic       ill;
    } obs_t;

    obs_t exp_q[$];

    localparam logic [6:0] LEGAL_OPS [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    localparam logic [6:0] BAD_OPS   [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};

    function automatic obs_t base(input logic [3:0] s);
        obs_t b;
        b = '0;
        b.st = s;
        return b;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus plus the response the architecture requires in that cycle.
    task automatic step(input logic rdy, input logic btk, input obs_t e);
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        bus.Btaken    = btk;
        exp_q.push_back(e);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #1;
        bus.mem_ready = 1'b0;
        n_rst = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        chk({tag, "_enables"}, 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemReq, bus.Branch}), 32'd0);
        @(posedge clk);
        #2;
        chk({tag, "_state_edge"}, 32'(bus.state_dbg), 32'd0);
        n_rst = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic bt, input int wf, input int wm, input int tc);
        obs_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        op = ir[6:0];
        f3 = ir[14:12];
        f7 = ir[30];
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;

        e = base(4'd0); e.mr = 1; e.sb = 2; e.rs = 2;
        for (int i = 0; i < wf; i++) step(1'b0, rb(), e);
        e.pcw = 1; e.irw = 1;
        step(1'b1, rb(), e);
        e = base(4'd1); e.sa = 1; e.sb = 1; e.imm = 2;
        step(rb(), rb(), e);

        case (op)
            7'h03, 7'h23: begin
                e = base(4'd2); e.sa = 2; e.sb = 1; e.imm = (op == 7'h23) ? 3'd1 : 3'd0;
                step(rb(), rb(), e);
                if (op == 7'h23) begin
                    e = base(4'd5); e.mr = 1; e.mw = 1; e.adr = 1;
                    for (int i = 0; i < wm; i++) step(1'b0, rb(), e);
                    step(1'b1, rb(), e);
                end else begin
                    e = base(4'd3); e.mr = 1; e.adr = 1;
                    for (int i = 0; i < wm; i++) step(1'b0, rb(), e);
                    step(1'b1, rb(), e);
                    e = base(4'd4); e.rs = 1; e.rw = 1;
                    step(rb(), rb(), e);
                end
            end
            7'h33, 7'h13: begin
                e = base((op == 7'h33) ? 4'd6 : 4'd7); e.sa = 2;
                e.sb  = (op == 7'h33) ? 2'd0 : 2'd1;
                // Subtract/arith-shift bit: R-type add/sub and srl/sra; I-type only srli/srai.
                e.alu = {1'b0, f3, ((f3 == 3'd5) || (op == 7'h33 && f3 == 3'd0)) ? f7 : 1'b0};
                step(rb(), rb(), e);
                e = base(4'd8); e.rw = 1;
                step(rb(), rb(), e);
            end
            7'h63: begin
                e = base(4'd9); e.sa = 2; e.alu = 5'b00001; e.br = 1; e.pcw = bt;
                step(rb(), bt, e);
            end
            7'h6F, 7'h67: begin
                e = base((op == 7'h6F) ? 4'd10 : 4'd11); e.pcw = 1;
                if (op == 7'h6F) begin e.sa = 1; e.sb = 2; end
                else begin e.sa = 2; e.sb = 1; e.rs = 2; end
                step(rb(), rb(), e);
                e = base(4'd8); e.rw = 1;
                step(rb(), rb(), e);
            end
            7'h37, 7'h17: begin
                e = base(4'd12); e.imm = 3; e.sb = 1; e.sa = (op == 7'h37) ? 2'd3 : 2'd1;
                step(rb(), rb(), e);
                e = base(4'd8); e.rw = 1;
                step(rb(), rb(), e);
            end
            default: begin
                e = base(4'd13); e.ill = 1;
                for (int i = 0; i < tc; i++) step(1'(i % 2), rb(), e);
                reset_pulse("trap_reset");
            end
        endcase
    endtask

    task automatic store_reset();
        obs_t e;
        bus.opcode = 7'h23; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0;
        e = base(4'd0); e.mr = 1; e.sb = 2; e.rs = 2; e.pcw = 1; e.irw = 1;
        step(1'b1, 1'b0, e);
        e = base(4'd1); e.sa = 1; e.sb = 1; e.imm = 2;
        step(1'b0, 1'b0, e);
        e = base(4'd2); e.sa = 2; e.sb = 1; e.imm = 1;
        step(1'b0, 1'b0, e);
        e = base(4'd5); e.mr = 1; e.mw = 1; e.adr = 1;
        step(1'b0, 1'b0, e);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_abort_pre_state", 32'(bus.state_dbg), 32'd5);
        chk("sw_abort_pre_strobes", 32'({bus.MemWrite, bus.MemReq}), 32'b11);
        n_rst = 1'b0;
        #1;
        chk("sw_abort_async_strobes", 32'({bus.MemWrite, bus.MemReq}), 32'b00);
        @(posedge clk);
        #2;
        chk("sw_abort_state", 32'(bus.state_dbg), 32'd0);
        n_rst = 1'b1;
        #1;
        chk("sw_abort_release_state", 32'(bus.state_dbg), 32'd0);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.st  = bus.state_dbg;  a.pcw = bus.PCWrite;  a.adr = bus.AdrSrc;
                a.mw  = bus.MemWrite;   a.mr  = bus.MemReq;   a.irw = bus.IRWrite;
                a.rw  = bus.RegWrite;   a.rs  = bus.ResultSrc; a.sa = bus.ALUSrc_A;
                a.sb  = bus.ALUSrc_B;   a.imm = bus.ImmSrc;   a.alu = bus.ALUControl;
                a.br  = bus.Branch;     a.ill = bus.illegal;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ctrl_outputs cycle=%0d act_state=%0d exp_state=%0d act=%h exp=%h",
                             cycle_no, a.st, e.st, a, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int k;
        logic [31:0] ir;
        bus.opcode = 7'h0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.Btaken = 1'b0; bus.mem_ready = 1'b0;
        #12;
        chk("reset_state", 32'(bus.state_dbg), 32'd0);
        chk("reset_illegal", 32'(bus.illegal), 32'd0);
        chk("reset_enables", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemReq, bus.Branch}), 32'd0);
        #5;
        n_rst = 1'b1;

        run_instr(32'h002081B3, 1'b0, 0, 0, 0);   // add
        run_instr(32'h402081B3, 1'b0, 0, 0, 0);   // sub
        run_instr(32'h4010D093, 1'b0, 1, 0, 0);   // srai
        run_instr(32'h40008093, 1'b0, 0, 0, 0);   // addi, IR[30]=1
        run_instr(32'h0000A083, 1'b0, 3, 3, 0);   // lw with waits
        run_instr(32'h0020A023, 1'b0, 1, 2, 0);   // sw with waits
        run_instr(32'h00208063, 1'b1, 0, 0, 0);   // beq taken
        run_instr(32'h00208063, 1'b0, 0, 0, 0);   // beq not taken
        run_instr(32'h0000006F, 1'b0, 0, 0, 0);   // jal
        run_instr(32'h00008067, 1'b0, 2, 0, 0);   // jalr
        run_instr(32'h000000B7, 1'b0, 0, 0, 0);   // lui
        run_instr(32'h00000097, 1'b0, 0, 0, 0);   // auipc
        run_instr(32'h0000007F, 1'b0, 0, 0, 20);  // illegal
        run_instr(32'h002081B3, 1'b0, 0, 0, 0);
        store_reset();
        run_instr(32'h002081B3, 1'b0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            ir = $urandom;
            k = $urandom_range(0, 19);
            if (k == 0) ir[6:0] = BAD_OPS[$urandom_range(0, 3)];
            else        ir[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
            run_instr(ir, rb(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
